// File: rtl/cpu_defs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_defs : opcode and step constants shared by control and datapath |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_defs;

    localparam int         C_REG_N  = 8;
    localparam logic [2:0] C_OP_MV  = 3'b000;
    localparam logic [2:0] C_OP_MVI = 3'b001;
    localparam logic [2:0] C_OP_ADD = 3'b010;
    localparam logic [2:0] C_OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

endpackage
`default_nettype wire

// File: rtl/dec3to8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dec3to8 : 3-to-8 one-hot decoder with enable                       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dec3to8
    import cpu_defs::*;
(
    input  logic [2:0]         i_sel,
    input  logic               i_en,
    output logic [C_REG_N-1:0] o_y
);

    always_comb begin
        o_y = '0;
        if (i_en) begin
            o_y[i_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_ctrl : T0..T3 sequencer for mv/mvi/add/sub on a shared bus     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cpu_ctrl
    import cpu_defs::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic              ir_in,
    output logic [7:0]        r_in,
    output logic [7:0]        r_out,
    output logic              g_out,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic              add_sub,
    output logic              done
);

    logic [DATA_W-1:0] r_ir;
    step_t             r_step;
    step_t             w_step_nxt;

    logic [2:0] w_opcode;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic       w_is_alu;
    logic       w_unused_ir;

    logic       w_ir_in;
    logic       w_rin_en;
    logic       w_rout_en;
    logic [2:0] w_rout_sel;
    logic       w_g_out;
    logic       w_din_out;
    logic       w_a_in;
    logic       w_g_in;
    logic       w_add_sub;
    logic       w_done;

    assign w_opcode    = r_ir[DATA_W-1 -: 3];
    assign w_x         = r_ir[DATA_W-4 -: 3];
    assign w_y         = r_ir[DATA_W-7 -: 3];
    assign w_is_alu    = (w_opcode == C_OP_ADD) || (w_opcode == C_OP_SUB);
    assign w_unused_ir = ^r_ir;

    // Instruction register: clears asynchronously, loads when ir_in is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= '0;
        end else if (ir_in) begin
            r_ir <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_nxt;
        end
    end

    always_comb begin
        w_ir_in    = 1'b0;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_sel = w_y;
        w_g_out    = 1'b0;
        w_din_out  = 1'b0;
        w_a_in     = 1'b0;
        w_g_in     = 1'b0;
        w_add_sub  = 1'b0;
        w_done     = 1'b0;
        w_step_nxt = r_step;

        case (r_step)
            T0: begin
                w_ir_in = run;
                if (run) begin
                    w_step_nxt = T1;
                end
            end
            T1: begin
                case (w_opcode)
                    C_OP_MV: begin
                        w_rout_en = 1'b1;
                        w_rin_en  = 1'b1;
                        w_done    = 1'b1;
                    end
                    C_OP_MVI: begin
                        w_din_out = 1'b1;
                        w_rin_en  = 1'b1;
                        w_done    = 1'b1;
                    end
                    C_OP_ADD, C_OP_SUB: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_x;
                        w_a_in     = 1'b1;
                    end
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (w_is_alu) begin
                    w_rout_en = 1'b1;
                    w_g_in    = 1'b1;
                    w_add_sub = w_opcode[0];
                end
            end
            T3: begin
                if (w_is_alu) begin
                    w_g_out  = 1'b1;
                    w_rin_en = 1'b1;
                    w_done   = 1'b1;
                end
            end
        endcase

        // Any step past T0 either finishes or moves on; run is not sampled here
        if (r_step != T0) begin
            w_step_nxt = w_done ? T0 : step_t'(r_step + 2'd1);
        end
    end

    dec3to8 u_dec_rin (
        .i_sel (w_x),
        .i_en  (w_rin_en & reset),
        .o_y   (r_in)
    );

    dec3to8 u_dec_rout (
        .i_sel (w_rout_sel),
        .i_en  (w_rout_en & reset),
        .o_y   (r_out)
    );

    // Reset forces every strobe low immediately, not only after the next edge
    assign ir_in   = w_ir_in   & reset;
    assign g_out   = w_g_out   & reset;
    assign din_out = w_din_out & reset;
    assign a_in    = w_a_in    & reset;
    assign g_in    = w_g_in    & reset;
    assign add_sub = w_add_sub & reset;
    assign done    = w_done    & reset;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_ctrl : directed and randomized checks of cpu_ctrl sequencing |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cpu_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic        ir_in;
    logic [7:0]  r_in;
    logic [7:0]  r_out;
    logic        g_out;
    logic        din_out;
    logic        a_in;
    logic        g_in;
    logic        add_sub;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    logic prev_done = 1'b0;

    logic [22:0] w_obs;
    assign w_obs = {ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub, done};

    cpu_ctrl #(.DATA_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .ir_in   (ir_in),
        .r_in    (r_in),
        .r_out   (r_out),
        .g_out   (g_out),
        .din_out (din_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [22:0] pk(input logic ir, input logic [7:0] ri, input logic [7:0] ro,
                                       input logic go, input logic dn, input logic a,
                                       input logic g, input logic as, input logic d);
        return {ir, ri, ro, go, dn, a, g, as, d};
    endfunction

    function automatic logic [7:0] oh(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'd1;
        return v << idx;
    endfunction

    // Per-instruction list of expected post-T0 cycles, from the instruction semantics
    function automatic void model(input logic [15:0] ins, output logic [22:0] e0,
                                  output logic [22:0] e1, output logic [22:0] e2, output int n);
        logic [2:0] op, x, y;
        op = ins[15:13];
        x  = ins[12:10];
        y  = ins[9:7];
        e0 = '0; e1 = '0; e2 = '0;
        if (op == 3'd0) begin
            n  = 1;
            e0 = pk(0, oh(x), oh(y), 0, 0, 0, 0, 0, 1);
        end else if (op == 3'd1) begin
            n  = 1;
            e0 = pk(0, oh(x), 8'h00, 0, 1, 0, 0, 0, 1);
        end else if (op == 3'd2 || op == 3'd3) begin
            n  = 3;
            e0 = pk(0, 8'h00, oh(x), 0, 0, 1, 0, 0, 0);
            e1 = pk(0, 8'h00, oh(y), 0, 0, 0, 1, (op == 3'd3), 0);
            e2 = pk(0, oh(x), 8'h00, 1, 0, 0, 0, 0, 1);
        end else begin
            n  = 1;
            e0 = pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        end
    endfunction

    // Every-cycle invariants: single bus driver and one-cycle done pulse
    always @(negedge clk) begin
        n_tests++;
        if (($countones(r_out) + int'(g_out) + int'(din_out)) > 1) begin
            n_fail++;
            $display("FAIL bus_excl: got r_out=%h g_out=%b din_out=%b expected at most one driver",
                     r_out, g_out, din_out);
        end
        n_tests++;
        if (done && prev_done) begin
            n_fail++;
            $display("FAIL done_width: got done high %0d cycles expected 1", 2);
        end
        prev_done = done;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        run   = 1'b1;
        din   = 16'h4280;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== 23'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h", w_obs, 23'h0);
            end
        end
        adv();
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_obs !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h expected %h", w_obs, 23'h0);
        end
        adv();
        run = 1'b1;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_t0_ir_in: got %h expected %h", w_obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        #1 run = 1'b0;
        adv();
    endtask

    task automatic test_mv();
        run = 1'b1;
        din = 16'h0A00;
        adv();
        run = 1'b0;
        din = 16'hFFFF;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h04, 8'h10, 0, 0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL mv_t1: got %h expected %h", w_obs, pk(0, 8'h04, 8'h10, 0, 0, 0, 0, 0, 1));
        end
        adv();
        run = 1'b1;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL mv_back_to_t0: got %h expected %h", w_obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        #1 run = 1'b0;
        adv();
    endtask

    task automatic test_mvi();
        run = 1'b1;
        din = 16'h2C00;
        adv();
        din = 16'h1234;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL mvi_t1: got %h expected %h", w_obs, pk(0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1));
        end
        #1 run = 1'b0;
        adv();
    endtask

    task automatic test_add();
        run = 1'b1;
        din = 16'h4280;
        adv();
        run = 1'b0;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL add_t1: got %h expected %h", w_obs, pk(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0));
        end
        adv();
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h00, 8'h20, 0, 0, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL add_t2: got %h expected %h", w_obs, pk(0, 8'h00, 8'h20, 0, 0, 0, 1, 0, 0));
        end
        adv();
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL add_t3: got %h expected %h", w_obs, pk(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
        end
        adv();
    endtask

    task automatic test_sub_reset();
        run = 1'b1;
        din = 16'h6680;
        adv();
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL sub_t1: got %h expected %h", w_obs, pk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
        end
        adv();
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 8'h00, 8'h20, 0, 0, 0, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL sub_t2: got %h expected %h", w_obs, pk(0, 8'h00, 8'h20, 0, 0, 0, 1, 1, 0));
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (w_obs !== 23'h0) begin
            n_fail++;
            $display("FAIL sub_reset_async: got %h expected %h", w_obs, 23'h0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== 23'h0) begin
                n_fail++;
                $display("FAIL sub_reset_held: got %h expected %h", w_obs, 23'h0);
            end
        end
        adv();
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (w_obs !== 23'h0) begin
                n_fail++;
                $display("FAIL sub_abandoned: got %h expected %h", w_obs, 23'h0);
            end
        end
        adv();
    endtask

    task automatic test_reserved();
        run = 1'b1;
        din = 16'hE000;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL rsv_t0: got %h expected %h", w_obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        adv();
        din = 16'h0A00;
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL rsv_t1_done_only: got %h expected %h", w_obs, pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        adv();
        @(negedge clk);
        n_tests++;
        if (w_obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL rsv_held_run_t0: got %h expected %h", w_obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        #1 run = 1'b0;
        adv();
    endtask

    task automatic test_random(input int n_instr, input bit no_gap);
        logic [15:0] ins, imm;
        logic [22:0] e0, e1, e2, ex;
        int          n, gap;
        for (int k = 0; k < n_instr; k++) begin
            ins = 16'($urandom);
            imm = 16'($urandom);
            model(ins, e0, e1, e2, n);
            gap = no_gap ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                run = 1'b0;
                din = 16'($urandom);
                @(negedge clk);
                n_tests++;
                if (w_obs !== 23'h0) begin
                    n_fail++;
                    $display("FAIL rand_idle: got %h expected %h", w_obs, 23'h0);
                end
                adv();
            end
            run = 1'b1;
            din = ins;
            @(negedge clk);
            n_tests++;
            if (w_obs !== pk(1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL rand_t0 ins=%h: got %h expected %h", ins, w_obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            adv();
            for (int i = 0; i < n; i++) begin
                run = 1'($urandom);
                din = (i == 0) ? imm : 16'($urandom);
                ex  = (i == 0) ? e0 : ((i == 1) ? e1 : e2);
                @(negedge clk);
                n_tests++;
                if (w_obs !== ex) begin
                    n_fail++;
                    $display("FAIL rand_step%0d ins=%h: got %h expected %h", i + 1, ins, w_obs, ex);
                end
                adv();
            end
        end
        run = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_random(40, 1'b1);
    endtask

    initial begin
        run   = 1'b0;
        din   = '0;
        reset = 1'b0;
        test_reset();
        test_mv();
        test_mvi();
        test_add();
        test_sub_reset();
        test_reserved();
        test_random(80, 1'b0);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
